vga_fb_write_arbiter: RTL and testbench
=======================================

Name: vga_fb_write_arbiter

Overview:
- Owns the write port of the 160x120, 1-bit frame buffer; the VGA signal generator reads the other port.
- Shares that write port between a single-pixel bus requester and an internal fill/clear engine, using round-robin while a fill runs.
- Also holds the foreground/background colour register and applies updates only at the start of vertical sync, so colour changes never tear mid-frame.

Parameters:
- H_PIXELS, 160, visible pixel columns
- V_PIXELS, 120, visible pixel rows
- X_BITS, 8, column address width
- Y_BITS, 7, row address width
- RESET_COLOURS, 16'hFF00, colour register reset value ([15:8] foreground, [7:0] background)

Ports:
- CLK  input  1  system clock (100 MHz); the only clock
- RESET  input  1  synchronous, active-high reset
- REQ_A  input  1  bus pixel-write request; held until GNT_A
- A_X  input  X_BITS  requested column
- A_Y  input  Y_BITS  requested row
- A_PIXEL  input  1  pixel value to write
- GNT_A  output  1  combinational; request accepted this cycle
- OOR_A  output  1  one-cycle pulse; accepted request was out of range and dropped
- FILL_START  input  1  pulse; start a fill with FILL_VALUE
- FILL_VALUE  input  1  value written to every pixel
- FILL_ABORT  input  1  pulse; stop the fill
- FILL_BUSY  output  1  high while the fill engine is active
- COL_WE  input  1  colour write strobe
- COL_DATA  input  16  new colour value
- VGA_VS  input  1  vertical sync from the signal generator (active low, generated from CLK)
- CONFIG_COLOURS  output  16  applied colour register
- FB_WE  output  1  frame buffer write enable
- FB_ADDR  output  15  frame buffer write address, {Y[6:0], X[7:0]}
- FB_DATA  output  1  frame buffer write data

Behaviour:
- Reset values: FB_WE=0, FB_ADDR=0, FB_DATA=0, FILL_BUSY=0, OOR_A=0, CONFIG_COLOURS=RESET_COLOURS, pending colour=RESET_COLOURS, state=IDLE, fill counters=0, last_grant=FILL, VS history register=1.
- Reset mid-fill aborts the fill immediately; no write is issued in the reset cycle.
- State IDLE:
  - GNT_A = REQ_A.
  - FILL_START moves to FILL on the next cycle, with X=0, Y=0 and FILL_VALUE latched.
  - If FILL_START and REQ_A arrive in the same cycle, the bus request is granted in that cycle and the fill starts next cycle.
- State FILL: one write slot per cycle. Round-robin arbitration:
  - If REQ_A is high and last_grant==FILL, the bus wins: GNT_A=1, last_grant becomes A.
  - Otherwise the fill wins: it issues the pixel at (X,Y), then X increments; at X=H_PIXELS-1, X wraps to 0 and Y increments. last_grant becomes FILL.
  - If REQ_A is low, the fill writes every cycle.
- Fill completion: after issuing (H_PIXELS-1, V_PIXELS-1), the engine returns to IDLE. FILL_BUSY drops in the same cycle as that final FB_WE. A full fill is 19200 fill writes.
- FILL_ABORT in FILL: return to IDLE next cycle. A bus grant in that cycle stands; no fill write is issued in that cycle.
- FILL_START while in FILL is ignored.
- Write latency: a grant or fill slot in cycle n produces FB_WE=1 with FB_ADDR/FB_DATA in cycle n+1 (registered outputs). FB_WE=0 otherwise; FB_ADDR/FB_DATA hold their last values.
- Out of range: a bus request with A_X>=H_PIXELS or A_Y>=V_PIXELS is still granted but produces no FB_WE. OOR_A pulses in cycle n+1.
- Bus write during a fill: the target pixel is overwritten when the fill sweep reaches it, if it has not passed it yet. This is intended.
- Colour register:
  - COL_WE loads the pending register.
  - A VS falling edge (registered VGA_VS==1 and current VGA_VS==0) copies pending into CONFIG_COLOURS on the next clock.
  - If COL_WE coincides with the falling-edge cycle, the apply uses the pending value from before the write; the new value is applied at the following falling edge.
  - Back-to-back COL_WE writes before an edge: last write wins.

Decomposition:
- Shared package vga_pkg: H_PIXELS, V_PIXELS, X_BITS, Y_BITS, the FB_ADDR packing function {Y,X}, the state enum (IDLE, FILL), and the grant enum (A, FILL).
- Natural sub-module: vga_colour_sync, containing the pending register, the VS edge detect and the apply logic.
- Arbiter, fill counters and the write-output register stay in the top module.

Test Plan:
- Reset, then REQ_A with (5,3,1) in IDLE -> GNT_A that cycle; next cycle FB_WE=1, FB_ADDR=15'h0305, FB_DATA=1.
- FILL_START with FILL_VALUE=0 and no bus traffic -> 19200 consecutive FB_WE; first address 0, address after X=159 is 15'h0100, last address 15'h779F; FILL_BUSY low after the final write.
- During a fill, hold REQ_A high for 3 requests -> grants alternate: FB_WE sequence bus, fill, bus, fill, bus; fill resumes at the correct X with no skipped or duplicated pixel.
- REQ_A with (160,0) -> GNT_A=1, no FB_WE, OOR_A pulses one cycle later; same for (0,120).
- COL_WE with 16'h1CE0 mid-frame -> CONFIG_COLOURS unchanged until the cycle after the VGA_VS falling edge, then 16'h1CE0. A second COL_WE in the edge cycle is applied one frame later.
- FILL_ABORT at pixel 500, then FILL_START -> fill restarts at address 0; RESET asserted mid-fill -> FB_WE=0, FILL_BUSY=0, CONFIG_COLOURS=16'hFF00 next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer write path.
//   - Frame geometry (160x120, 1 bit per pixel) and address widths.
//   - Sized limit constants so comparisons stay width-matched.
//   - FB_ADDR packing helper: {row, column}.
//   - Arbiter state and last-grant encodings.
package vga_pkg;

    localparam int H_PIXELS  = 160;
    localparam int V_PIXELS  = 120;
    localparam int X_BITS    = 8;
    localparam int Y_BITS    = 7;
    localparam int ADDR_BITS = X_BITS + Y_BITS;

    // First out-of-range coordinate and last valid coordinate per axis.
    localparam logic [X_BITS-1:0] X_LIMIT = X_BITS'(H_PIXELS);
    localparam logic [Y_BITS-1:0] Y_LIMIT = Y_BITS'(V_PIXELS);
    localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(H_PIXELS - 1);
    localparam logic [Y_BITS-1:0] Y_LAST  = Y_BITS'(V_PIXELS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    // Which requester took the previous FILL-state write slot.
    typedef enum logic {
        GRANT_A,
        GRANT_FILL
    } grant_t;

    function automatic logic [ADDR_BITS-1:0] fb_addr_pack(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_colour_sync.sv
// Foreground/background colour register with vertical-sync-aligned apply.
// A write lands in a pending register; the pending value is copied to the
// applied register only at the start of vertical sync, so the picture never
// changes colour part-way through a frame.
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   COL_WE         load COL_DATA into the pending register
//   COL_DATA       new colour value ([15:8] foreground, [7:0] background)
//   VGA_VS         vertical sync, active low, generated from CLK
//   CONFIG_COLOURS applied colour register
module vga_colour_sync #(
    parameter logic [15:0] RESET_COLOURS = 16'hFF00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        COL_WE,
    input  logic [15:0] COL_DATA,
    input  logic        VGA_VS,
    output logic [15:0] CONFIG_COLOURS
);

    logic [15:0] pending;
    logic        vs_q;
    logic        vs_fall;

    // Sync is already in the CLK domain, so a single history flop suffices.
    assign vs_fall = vs_q & ~VGA_VS;

    // NOTE: non-blocking assignments make every right-hand side read the
    // pre-edge value, so a COL_WE in the edge cycle applies the old pending
    // value and the new one waits for the next frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_q           <= 1'b1;
            pending        <= RESET_COLOURS;
            CONFIG_COLOURS <= RESET_COLOURS;
        end else begin
            vs_q <= VGA_VS;
            if (COL_WE) begin
                pending <= COL_DATA;
            end
            if (vs_fall) begin
                CONFIG_COLOURS <= pending;
            end
        end
    end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Owner of the frame-buffer write port. A single-pixel bus requester and an
// internal fill/clear engine share one write slot per cycle; while a fill
// runs they alternate round-robin. Writes are registered: a grant or fill
// slot in cycle n shows up on FB_WE/FB_ADDR/FB_DATA in cycle n+1.
//   CLK, RESET           clock, synchronous active-high reset
//   REQ_A/A_X/A_Y/A_PIXEL bus pixel-write request, held until GNT_A
//   GNT_A                combinational accept of the bus request
//   OOR_A                pulse: accepted request was out of range, dropped
//   FILL_START/VALUE     start a whole-frame fill with FILL_VALUE
//   FILL_ABORT           stop a running fill
//   FILL_BUSY            fill engine active
//   COL_WE/COL_DATA      colour register write
//   VGA_VS               vertical sync (active low) for colour apply
//   CONFIG_COLOURS       applied colour register
//   FB_WE/FB_ADDR/FB_DATA frame-buffer write port, FB_ADDR = {Y, X}
module vga_fb_write_arbiter
    import vga_pkg::*;
#(
    parameter logic [15:0] RESET_COLOURS = 16'hFF00
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ_A,
    input  logic [X_BITS-1:0]    A_X,
    input  logic [Y_BITS-1:0]    A_Y,
    input  logic                 A_PIXEL,
    output logic                 GNT_A,
    output logic                 OOR_A,
    input  logic                 FILL_START,
    input  logic                 FILL_VALUE,
    input  logic                 FILL_ABORT,
    output logic                 FILL_BUSY,
    input  logic                 COL_WE,
    input  logic [15:0]          COL_DATA,
    input  logic                 VGA_VS,
    output logic [15:0]          CONFIG_COLOURS,
    output logic                 FB_WE,
    output logic [ADDR_BITS-1:0] FB_ADDR,
    output logic                 FB_DATA
);

    state_t              state, state_next;
    grant_t              last_grant, last_grant_next;
    logic [X_BITS-1:0]   fill_x;
    logic [Y_BITS-1:0]   fill_y;
    logic                fill_value;
    logic                fill_slot;
    logic                fill_last;
    logic                a_in_range;

    assign fill_last  = (fill_x == X_LAST) && (fill_y == Y_LAST);
    assign a_in_range = (A_X < X_LIMIT) && (A_Y < Y_LIMIT);
    // The final fill slot moves state to IDLE, so busy drops in the same
    // cycle that the last fill write appears on FB_WE.
    assign FILL_BUSY  = (state == FILL);

    // NOTE: every always_comb output gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        GNT_A           = 1'b0;
        fill_slot       = 1'b0;
        unique case (state)
            IDLE: begin
                GNT_A = REQ_A;
                if (FILL_START) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (REQ_A && last_grant == GRANT_FILL) begin
                    GNT_A           = 1'b1;
                    last_grant_next = GRANT_A;
                end else if (!FILL_ABORT) begin
                    fill_slot       = 1'b1;
                    last_grant_next = GRANT_FILL;
                end
                // A bus grant in the abort cycle still completes.
                if (FILL_ABORT || (fill_slot && fill_last)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            last_grant <= GRANT_FILL;
            fill_x     <= '0;
            fill_y     <= '0;
            fill_value <= 1'b0;
            FB_WE      <= 1'b0;
            FB_ADDR    <= '0;
            FB_DATA    <= 1'b0;
            OOR_A      <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;

            if (state == IDLE && FILL_START) begin
                fill_x     <= '0;
                fill_y     <= '0;
                fill_value <= FILL_VALUE;
            end else if (fill_slot) begin
                if (fill_x == X_LAST) begin
                    fill_x <= '0;
                    fill_y <= fill_y + 1'b1;
                end else begin
                    fill_x <= fill_x + 1'b1;
                end
            end

            // Address and data hold their last values when nothing is written.
            FB_WE <= 1'b0;
            OOR_A <= 1'b0;
            if (GNT_A) begin
                if (a_in_range) begin
                    FB_WE   <= 1'b1;
                    FB_ADDR <= fb_addr_pack(A_X, A_Y);
                    FB_DATA <= A_PIXEL;
                end else begin
                    OOR_A <= 1'b1;
                end
            end else if (fill_slot) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= fb_addr_pack(fill_x, fill_y);
                FB_DATA <= fill_value;
            end
        end
    end

    vga_colour_sync #(
        .RESET_COLOURS (RESET_COLOURS)
    ) u_colour_sync (
        .CLK            (CLK),
        .RESET          (RESET),
        .COL_WE         (COL_WE),
        .COL_DATA       (COL_DATA),
        .VGA_VS         (VGA_VS),
        .CONFIG_COLOURS (CONFIG_COLOURS)
    );

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed self-checking bench for vga_fb_write_arbiter.
module tb_vga_fb_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_A;
    logic [7:0]  A_X;
    logic [6:0]  A_Y;
    logic        A_PIXEL;
    logic        GNT_A;
    logic        OOR_A;
    logic        FILL_START;
    logic        FILL_VALUE;
    logic        FILL_ABORT;
    logic        FILL_BUSY;
    logic        COL_WE;
    logic [15:0] COL_DATA;
    logic        VGA_VS;
    logic [15:0] CONFIG_COLOURS;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;

    int tests_run = 0;
    int tests_failed = 0;

    vga_fb_write_arbiter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .REQ_A          (REQ_A),
        .A_X            (A_X),
        .A_Y            (A_Y),
        .A_PIXEL        (A_PIXEL),
        .GNT_A          (GNT_A),
        .OOR_A          (OOR_A),
        .FILL_START     (FILL_START),
        .FILL_VALUE     (FILL_VALUE),
        .FILL_ABORT     (FILL_ABORT),
        .FILL_BUSY      (FILL_BUSY),
        .COL_WE         (COL_WE),
        .COL_DATA       (COL_DATA),
        .VGA_VS         (VGA_VS),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .FB_WE          (FB_WE),
        .FB_ADDR        (FB_ADDR),
        .FB_DATA        (FB_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int fill_bad;
        logic [14:0] exp_addr;

        RESET = 1'b1; REQ_A = 1'b0; A_X = '0; A_Y = '0; A_PIXEL = 1'b0;
        FILL_START = 1'b0; FILL_VALUE = 1'b0; FILL_ABORT = 1'b0;
        COL_WE = 1'b0; COL_DATA = '0; VGA_VS = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_fb_we", FB_WE, 0);
        check("rst_fb_addr", FB_ADDR, 0);
        check("rst_fb_data", FB_DATA, 0);
        check("rst_busy", FILL_BUSY, 0);
        check("rst_oor", OOR_A, 0);
        check("rst_colours", CONFIG_COLOURS, 16'hFF00);
        RESET = 1'b0;
        tick();

        // Single bus write in IDLE.
        REQ_A = 1'b1; A_X = 8'd5; A_Y = 7'd3; A_PIXEL = 1'b1;
        #1 check("idle_gnt", GNT_A, 1);
        tick();
        REQ_A = 1'b0;
        check("idle_we", FB_WE, 1);
        check("idle_addr", FB_ADDR, 15'h0305);
        check("idle_data", FB_DATA, 1);
        tick();
        check("idle_we_off", FB_WE, 0);
        check("idle_addr_hold", FB_ADDR, 15'h0305);

        // Out-of-range column.
        REQ_A = 1'b1; A_X = 8'd160; A_Y = 7'd0; A_PIXEL = 1'b1;
        #1 check("oorx_gnt", GNT_A, 1);
        tick();
        REQ_A = 1'b0;
        check("oorx_we", FB_WE, 0);
        check("oorx_pulse", OOR_A, 1);
        tick();
        check("oorx_pulse_end", OOR_A, 0);

        // Out-of-range row.
        REQ_A = 1'b1; A_X = 8'd0; A_Y = 7'd120;
        #1 check("oory_gnt", GNT_A, 1);
        tick();
        REQ_A = 1'b0;
        check("oory_we", FB_WE, 0);
        check("oory_pulse", OOR_A, 1);
        check("oory_addr_hold", FB_ADDR, 15'h0305);
        tick();
        check("oory_pulse_end", OOR_A, 0);

        // Full fill with value 0 and no bus traffic.
        FILL_VALUE = 1'b0; FILL_START = 1'b1;
        tick();
        FILL_START = 1'b0;
        check("fill_busy_on", FILL_BUSY, 1);
        check("fill_first_we_pending", FB_WE, 0);
        fill_bad = 0;
        for (int i = 0; i < 19200; i++) begin
            tick();
            exp_addr = {7'(i / 160), 8'(i % 160)};
            if (FB_WE !== 1'b1 || FB_ADDR !== exp_addr || FB_DATA !== 1'b0) fill_bad++;
            if (i < 19199 && FILL_BUSY !== 1'b1) fill_bad++;
            if (i == 0) check("fill_addr_first", FB_ADDR, 15'h0000);
            if (i == 160) check("fill_addr_row1", FB_ADDR, 15'h0100);
            if (i == 19199) begin
                check("fill_addr_last", FB_ADDR, 15'h779F);
                check("fill_busy_off_at_last", FILL_BUSY, 0);
            end
        end
        check("fill_sequence_errors", fill_bad, 0);
        tick();
        check("fill_done_we", FB_WE, 0);

        // Round-robin during a fill of value 1.
        FILL_VALUE = 1'b1; FILL_START = 1'b1;
        tick();
        FILL_START = 1'b0;
        REQ_A = 1'b1; A_X = 8'd10; A_Y = 7'd20; A_PIXEL = 1'b0;
        #1 check("rr_gnt1", GNT_A, 1);
        tick();
        check("rr_wr_bus1", FB_ADDR, 15'h140A);
        check("rr_wr_bus1_data", FB_DATA, 0);
        A_X = 8'd11; A_Y = 7'd21;
        #1 check("rr_gnt_fill0", GNT_A, 0);
        tick();
        check("rr_wr_fill0", FB_ADDR, 15'h0000);
        check("rr_wr_fill0_data", FB_DATA, 1);
        check("rr_gnt2", GNT_A, 1);
        tick();
        check("rr_wr_bus2", FB_ADDR, 15'h150B);
        A_X = 8'd12; A_Y = 7'd22;
        #1 check("rr_gnt_fill1", GNT_A, 0);
        tick();
        check("rr_wr_fill1", FB_ADDR, 15'h0001);
        check("rr_gnt3", GNT_A, 1);
        tick();
        REQ_A = 1'b0;
        check("rr_wr_bus3", FB_ADDR, 15'h160C);
        check("rr_wr_bus3_we", FB_WE, 1);
        tick();
        check("rr_wr_fill2", FB_ADDR, 15'h0002);
        tick();
        check("rr_wr_fill3", FB_ADDR, 15'h0003);
        check("rr_wr_fill3_we", FB_WE, 1);

        // Run on to pixel 500 and abort there.
        for (int i = 0; i < 496; i++) tick();
        check("abort_prev_pixel", FB_ADDR, 15'h0313);
        FILL_ABORT = 1'b1;
        tick();
        FILL_ABORT = 1'b0;
        check("abort_no_write", FB_WE, 0);
        check("abort_busy_off", FILL_BUSY, 0);
        check("abort_addr_hold", FB_ADDR, 15'h0313);
        FILL_VALUE = 1'b0; FILL_START = 1'b1;
        tick();
        FILL_START = 1'b0;
        check("restart_busy", FILL_BUSY, 1);
        tick();
        check("restart_we", FB_WE, 1);
        check("restart_addr", FB_ADDR, 15'h0000);

        // Colour register apply on VS falling edge (fill keeps running).
        COL_WE = 1'b1; COL_DATA = 16'h1CE0;
        tick();
        COL_WE = 1'b0;
        check("col_pending_only", CONFIG_COLOURS, 16'hFF00);
        tick();
        check("col_still_old", CONFIG_COLOURS, 16'hFF00);
        VGA_VS = 1'b0; COL_WE = 1'b1; COL_DATA = 16'h0ABC;
        #1 check("col_edge_cycle", CONFIG_COLOURS, 16'hFF00);
        tick();
        COL_WE = 1'b0;
        check("col_applied", CONFIG_COLOURS, 16'h1CE0);
        tick();
        check("col_edge_write_deferred", CONFIG_COLOURS, 16'h1CE0);
        VGA_VS = 1'b1;
        tick();
        tick();
        VGA_VS = 1'b0;
        tick();
        check("col_next_frame", CONFIG_COLOURS, 16'h0ABC);
        VGA_VS = 1'b1;
        COL_WE = 1'b1; COL_DATA = 16'h1111;
        tick();
        COL_DATA = 16'h2222;
        tick();
        COL_WE = 1'b0; VGA_VS = 1'b0;
        tick();
        check("col_last_write_wins", CONFIG_COLOURS, 16'h2222);
        VGA_VS = 1'b1;

        // Reset in the middle of the fill.
        check("pre_reset_busy", FILL_BUSY, 1);
        RESET = 1'b1;
        tick();
        check("midrst_we", FB_WE, 0);
        check("midrst_busy", FILL_BUSY, 0);
        check("midrst_colours", CONFIG_COLOURS, 16'hFF00);
        RESET = 1'b0;
        tick();
        check("post_rst_idle_we", FB_WE, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
